// File: rtl/fifo_pong_unpack_pkg.sv
// Shared widths and types for the ping-pong FIFO drain path.
package fifo_pong_unpack_pkg;

  localparam int unsigned WORD_WIDTH = 704;
  localparam int unsigned BEAT_WIDTH = 32;
  localparam int unsigned BEATS      = WORD_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_WIDTH  = 5;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  localparam cnt_t LAST_CNT = CNT_WIDTH'(BEATS - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_pong_unpack_if.sv
// Upstream first/deq and downstream beat first/deq handshakes.
interface fifo_pong_unpack_if;
  import fifo_pong_unpack_pkg::*;

  word_t src_first;
  logic  src_first__RDY;
  logic  src_deq__RDY;
  logic  src_deq__ENA;
  beat_t out_first;
  logic  out_first__RDY;
  logic  out_last;
  logic  out_deq__ENA;
  logic  out_deq__RDY;

  // Unpacker side
  modport master (
    input  src_first, src_first__RDY, src_deq__RDY, out_deq__ENA,
    output src_deq__ENA, out_first, out_first__RDY, out_last, out_deq__RDY
  );

  // Environment side: upstream FIFO plus narrow consumer
  modport slave (
    output src_first, src_first__RDY, src_deq__RDY, out_deq__ENA,
    input  src_deq__ENA, out_first, out_first__RDY, out_last, out_deq__RDY
  );

endinterface

// File: rtl/fifo_pong_unpack.sv
// Splits each 704-bit upstream element into 22 32-bit beats, LSB beat first,
// reloading on the last beat so back-to-back elements leave no bubble.
module fifo_pong_unpack
  import fifo_pong_unpack_pkg::*;
(
  input logic                CLK,
  input logic                nRST,
  fifo_pong_unpack_if.master bus
);

  state_e state_q, state_d;
  word_t  shreg_q, shreg_d;
  cnt_t   cnt_q,   cnt_d;
  logic   full, last_beat, deq_int, take;

  // State register, shift register and beat counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_EMPTY;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; upstream pop is gated by reset so a held reset never reads ahead
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    full      = (state_q == ST_HOLD);
    last_beat = (cnt_q == LAST_CNT);
    deq_int   = bus.out_deq__ENA & full;
    take      = nRST & bus.src_first__RDY & bus.src_deq__RDY
              & (~full | (deq_int & last_beat));

    case (state_q)
      ST_EMPTY: begin
        if (take) begin
          state_d = ST_HOLD;
          shreg_d = bus.src_first;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (deq_int) begin
          if (!last_beat) begin
            shreg_d = shreg_q >> BEAT_WIDTH;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
          end else if (take) begin
            shreg_d = bus.src_first;
            cnt_d   = '0;
          end else begin
            state_d = ST_EMPTY;
            shreg_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state; only the pop strobe sees inputs
  assign bus.src_deq__ENA   = take;
  assign bus.out_first      = shreg_q[BEAT_WIDTH-1:0];
  assign bus.out_first__RDY = full;
  assign bus.out_deq__RDY   = full;
  assign bus.out_last       = full & last_beat;

endmodule

// File: tb/tb_fifo_pong_unpack.sv
// Bench for fifo_pong_unpack: element-level model plus directed scenarios.
module tb_fifo_pong_unpack;
  import fifo_pong_unpack_pkg::*;

  logic CLK;
  logic nRST;

  fifo_pong_unpack_if bus ();

  fifo_pong_unpack dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic word_t make_elem(input int base);
    word_t e;
    e = '0;
    for (int k = 0; k < int'(BEATS); k++) e[k*BEAT_WIDTH +: BEAT_WIDTH] = 32'(base + k);
    return e;
  endfunction

  // Element-level model: which element is held and which beat index is shown
  word_t m_elem;
  int    m_k;
  bit    m_valid;

  function automatic bit model_take();
    return nRST && bus.src_first__RDY && bus.src_deq__RDY &&
           (!m_valid || (bus.out_deq__ENA && m_k == int'(BEATS) - 1));
  endfunction

  function automatic logic [31:0] model_first();
    return m_valid ? m_elem[m_k*BEAT_WIDTH +: BEAT_WIDTH] : 32'h0;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_valid = 1'b0;
      m_k     = 0;
      m_elem  = '0;
    end else begin
      bit pop, consume;
      pop     = model_take();
      consume = m_valid && bus.out_deq__ENA;
      if (consume && m_k < int'(BEATS) - 1) m_k = m_k + 1;
      else if (pop) begin
        m_elem  = bus.src_first;
        m_k     = 0;
        m_valid = 1'b1;
      end else if (consume) begin
        m_valid = 1'b0;
        m_k     = 0;
      end
    end
  end

  // Observation log
  logic [31:0] beats_q[$];
  int cyc = 0;
  int pop_cnt, last_idx, coincide, first_cyc, last_cyc, first_pop_cyc;
  bit ena_seen = 1'b0;

  task automatic clear_log();
    beats_q.delete();
    pop_cnt = 0; last_idx = -1; coincide = 0;
    first_cyc = -1; last_cyc = -1; first_pop_cyc = -1;
  endtask

  // Compare process: every cycle, mid-period
  always @(negedge CLK) begin
    cyc++;
    check("out_first",      bus.out_first,                model_first());
    check("out_first__RDY", 32'(bus.out_first__RDY),      32'(m_valid));
    check("out_deq__RDY",   32'(bus.out_deq__RDY),        32'(m_valid));
    check("out_last",       32'(bus.out_last),            32'(m_valid && m_k == int'(BEATS) - 1));
    check("src_deq__ENA",   32'(bus.src_deq__ENA),        32'(model_take()));
    ena_seen = bus.src_deq__ENA;
    if (bus.src_deq__ENA) begin
      if (pop_cnt == 0) first_pop_cyc = cyc;
      pop_cnt++;
    end
    if (bus.out_deq__RDY && bus.out_deq__ENA) begin
      if (beats_q.size() == 0) first_cyc = cyc;
      last_cyc = cyc;
      if (bus.out_last) begin
        last_idx = beats_q.size();
        if (bus.src_deq__ENA) coincide++;
      end
      beats_q.push_back(bus.out_first);
    end
  end

  // Upstream FIFO stand-in
  word_t up_q[$];

  task automatic drive_up();
    bus.src_first      = (up_q.size() > 0) ? up_q[0] : '0;
    bus.src_first__RDY = (up_q.size() > 0);
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
    if (ena_seen && up_q.size() > 0) void'(up_q.pop_front());
    drive_up();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t = 0;
    while (beats_q.size() < n && t < budget) begin
      cycle();
      t++;
    end
    check("beat_wait", 32'(beats_q.size() >= n), 32'd1);
  endtask

  function automatic int seq_errs(input int from, input int cnt, input int base);
    int e = 0;
    for (int k = 0; k < cnt; k++)
      if (from + k >= beats_q.size() || beats_q[from+k] !== 32'(base + k)) e++;
    return e;
  endfunction

  initial begin
    nRST = 1'b0;
    bus.src_first      = '0;
    bus.src_first__RDY = 1'b0;
    bus.src_deq__RDY   = 1'b0;
    bus.out_deq__ENA   = 1'b0;
    clear_log();
    repeat (3) cycle();
    check("rst_first", bus.out_first, 32'h0);
    check("rst_rdy",   32'(bus.out_first__RDY), 32'd0);
    nRST = 1'b1;

    // Idle: no element, upstream deq callable
    bus.src_deq__RDY = 1'b1;
    repeat (10) cycle();
    check("idle_pops", 32'(pop_cnt), 32'd0);

    // One element, sink always ready
    clear_log();
    up_q.push_back(make_elem(32'hA000));
    drive_up();
    bus.out_deq__ENA = 1'b1;
    wait_beats(22, 60);
    check("one_rdy_drop",  32'(bus.out_first__RDY), 32'd0);
    check("one_pops",      32'(pop_cnt), 32'd1);
    check("one_seq",       32'(seq_errs(0, 22, 32'hA000)), 32'd0);
    check("one_beat21",    beats_q[21], 32'hA015);
    check("one_last_idx",  32'(last_idx), 32'd21);
    check("one_latency",   32'(first_cyc - first_pop_cyc), 32'd1);
    check("one_span",      32'(last_cyc - first_cyc), 32'd21);

    // Two elements back to back
    clear_log();
    up_q.push_back(make_elem(32'h1000));
    up_q.push_back(make_elem(32'h2000));
    drive_up();
    wait_beats(44, 100);
    check("two_seq_a",    32'(seq_errs(0, 22, 32'h1000)), 32'd0);
    check("two_seq_b",    32'(seq_errs(22, 22, 32'h2000)), 32'd0);
    check("two_pops",     32'(pop_cnt), 32'd2);
    check("two_coincide", 32'(coincide), 32'd1);
    check("two_span",     32'(last_cyc - first_cyc), 32'd43);

    // Sink stall at beat 7 with upstream ready
    clear_log();
    up_q.push_back(make_elem(32'hA000));
    up_q.push_back(make_elem(32'h5000));
    drive_up();
    wait_beats(7, 40);
    bus.out_deq__ENA = 1'b0;
    check("stall_hold0", bus.out_first, 32'hA007);
    for (int s = 0; s < 5; s++) begin
      cycle();
      check("stall_hold",  bus.out_first, 32'hA007);
      check("stall_last",  32'(bus.out_last), 32'd0);
      check("stall_nopop", 32'(pop_cnt), 32'd1);
    end
    bus.out_deq__ENA = 1'b1;
    wait_beats(44, 100);
    check("stall_seq_a", 32'(seq_errs(0, 22, 32'hA000)), 32'd0);
    check("stall_seq_b", 32'(seq_errs(22, 22, 32'h5000)), 32'd0);
    check("stall_span",  32'(last_cyc - first_cyc), 32'd48);

    // Reset mid-element at beat 10
    clear_log();
    up_q.push_back(make_elem(32'hB000));
    up_q.push_back(make_elem(32'hC000));
    drive_up();
    wait_beats(10, 40);
    check("pre_rst_beat", bus.out_first, 32'hB00A);
    nRST = 1'b0;
    #1;
    check("arst_first", bus.out_first, 32'h0);
    check("arst_rdy",   32'(bus.out_first__RDY), 32'd0);
    check("arst_drdy",  32'(bus.out_deq__RDY), 32'd0);
    check("arst_last",  32'(bus.out_last), 32'd0);
    check("arst_ena",   32'(bus.src_deq__ENA), 32'd0);
    cycle();
    cycle();
    check("arst_upq", 32'(up_q.size()), 32'd1);
    nRST = 1'b1;
    clear_log();
    wait_beats(22, 60);
    check("post_rst_seq",  32'(seq_errs(0, 22, 32'hC000)), 32'd0);
    check("post_rst_last", 32'(last_idx), 32'd21);
    check("post_rst_pops", 32'(pop_cnt), 32'd1);
    cycle();

    // Spurious enable while empty
    clear_log();
    for (int s = 0; s < 5; s++) begin
      cycle();
      check("spur_rdy", 32'(bus.out_first__RDY), 32'd0);
    end
    check("spur_pops",  32'(pop_cnt), 32'd0);
    check("spur_beats", 32'(beats_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
